audio_decimator: RTL

Decimate-by-2^LOG2_R stage between `audio_codec_data` and `fft_stream` in the microphone path. It takes one 16-bit two's-complement codec sample per input handshake. It emits one 32-bit FFT-format word per 2^LOG2_R inputs, as either a boxcar average or the last sample of the block. The output is held in a single-entry register until the FFT accepts it. Results that cannot be held are discarded and counted.

---
 rtl/audio_dsp_pkg.sv | 17 +
 rtl/decim_accumulator.sv | 84 ++++++++
 rtl/audio_decimator.sv | 108 ++++++++++
 3 files changed

// File: rtl/audio_dsp_pkg.sv
// audio_dsp_pkg: shared widths and types for the microphone DSP path
// (audio_codec_data -> audio_decimator -> fft_stream).
//   DECIM_LOG2_R : log2 of the decimation ratio
//   AUDIO_W      : codec sample width (two's complement)
//   FFT_W        : FFT input word width
//   FFT_FRAC     : zero LSBs appended below the sample in an FFT word
package audio_dsp_pkg;

  localparam int unsigned DECIM_LOG2_R = 6;
  localparam int unsigned AUDIO_W      = 16;
  localparam int unsigned FFT_W        = 32;
  localparam int unsigned FFT_FRAC     = 8;

  typedef logic signed [AUDIO_W-1:0] audio_sample_t;
  typedef logic        [FFT_W-1:0]   fft_word_t;

endpackage

// File: rtl/decim_accumulator.sv
// decim_accumulator: block counter and boxcar accumulator for the decimator.
// Produces a combinational one-cycle result pulse on the accept that closes a
// block of 2^LOG2_R inputs; the caller registers it.
// Ports:
//   clk          : adc_clk domain clock
//   reset        : synchronous, active-high
//   in_valid     : an input sample is accepted this cycle
//   in_data      : two's-complement input sample
//   result_valid : high on the accept that completes a block
//   result       : block average (AVERAGE=1) or last sample of the block (AVERAGE=0)
module decim_accumulator
  import audio_dsp_pkg::*;
#(
  parameter int unsigned IN_W    = AUDIO_W,
  parameter int unsigned LOG2_R  = DECIM_LOG2_R,
  parameter bit          AVERAGE = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [IN_W-1:0] in_data,
  output logic            result_valid,
  output logic [IN_W-1:0] result
);

  localparam int unsigned AccW = IN_W + LOG2_R;

  logic [LOG2_R-1:0] blk_cnt_q, blk_cnt_d;
  logic              blk_last;

  assign blk_last     = (blk_cnt_q == {LOG2_R{1'b1}});
  assign result_valid = in_valid & blk_last;

  // Natural wrap from R-1 to 0 since R is a power of two.
  always_comb begin
    blk_cnt_d = blk_cnt_q;
    if (in_valid) begin
      blk_cnt_d = blk_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blk_cnt_q <= '0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
    end
  end

  if (AVERAGE) begin : g_avg
    logic signed [AccW-1:0] acc_q, acc_d;
    logic signed [AccW-1:0] data_ext;
    logic signed [AccW-1:0] sum;
    logic                   unused_sum_lsbs;

    assign data_ext = AccW'($signed(in_data));
    assign sum      = acc_q + data_ext;

    // Clear on the closing accept so the next block starts from zero.
    always_comb begin
      acc_d = acc_q;
      if (in_valid) begin
        acc_d = blk_last ? '0 : sum;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        acc_q <= '0;
      end else begin
        acc_q <= acc_d;
      end
    end

    // Dropping the low LOG2_R bits of a two's-complement sum is an arithmetic
    // shift right, i.e. floor division by R. The sum of R samples always fits
    // in AccW bits, so the quotient fits back into IN_W bits.
    assign result          = sum[AccW-1:LOG2_R];
    assign unused_sum_lsbs = ^sum[LOG2_R-1:0];
  end else begin : g_pick
    assign result = in_data;
  end

endmodule

// File: rtl/audio_decimator.sv
// audio_decimator: decimate-by-2^LOG2_R stage between the codec and the FFT.
// One OUT_W word per R accepted inputs, held in a single-entry output register
// until the FFT takes it. Results arriving while the register is full and not
// being drained are discarded and counted.
// Ports:
//   clk        : adc_clk domain clock
//   reset      : synchronous, active-high
//   x_valid    : codec sample valid
//   x_ready    : always 1 (the codec cannot be stalled)
//   x_data     : codec sample, two's complement
//   y_valid    : output word valid
//   y_ready    : FFT accepts the output word
//   y_data     : {sign extension, result, FRAC zeros}
//   drop_count : saturating count of discarded results
//   overflow   : sticky, set on the first discarded result
module audio_decimator
  import audio_dsp_pkg::*;
#(
  parameter int unsigned IN_W    = AUDIO_W,
  parameter int unsigned OUT_W   = FFT_W,
  parameter int unsigned LOG2_R  = DECIM_LOG2_R,
  parameter int unsigned FRAC    = FFT_FRAC,
  parameter bit          AVERAGE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x_valid,
  output logic             x_ready,
  input  logic [IN_W-1:0]  x_data,
  output logic             y_valid,
  input  logic             y_ready,
  output logic [OUT_W-1:0] y_data,
  output logic [15:0]      drop_count,
  output logic             overflow
);

  logic             res_valid;
  logic [IN_W-1:0]  res;
  logic [OUT_W-1:0] res_word;

  logic             y_valid_q, y_valid_d;
  logic [OUT_W-1:0] y_data_q, y_data_d;
  logic [15:0]      drop_count_q, drop_count_d;
  logic             overflow_q, overflow_d;
  logic             load;
  logic             drop;

  assign x_ready = 1'b1;

  decim_accumulator #(
    .IN_W    (IN_W),
    .LOG2_R  (LOG2_R),
    .AVERAGE (AVERAGE)
  ) u_accumulator (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (x_valid),
    .in_data      (x_data),
    .result_valid (res_valid),
    .result       (res)
  );

  // Sign-extend to OUT_W, then move the sample up above the FRAC zero LSBs.
  assign res_word = OUT_W'($signed(res)) << FRAC;

  // A concurrent drain frees the register, so the new result is not dropped.
  assign load = res_valid & (~y_valid_q | y_ready);
  assign drop = res_valid & y_valid_q & ~y_ready;

  always_comb begin
    y_valid_d    = y_valid_q;
    y_data_d     = y_data_q;
    drop_count_d = drop_count_q;
    overflow_d   = overflow_q;
    if (load) begin
      y_valid_d = 1'b1;
      y_data_d  = res_word;
    end else if (y_ready) begin
      y_valid_d = 1'b0;
    end
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_count_q != 16'hFFFF) begin
        drop_count_d = drop_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_valid_q    <= 1'b0;
      y_data_q     <= '0;
      drop_count_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      y_valid_q    <= y_valid_d;
      y_data_q     <= y_data_d;
      drop_count_q <= drop_count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign y_valid    = y_valid_q;
  assign y_data     = y_data_q;
  assign drop_count = drop_count_q;
  assign overflow   = overflow_q;

endmodule
